// File: rtl/panel_controller.sv
// Front-panel controller: switch command decode, panel memory access
// and lamp drive for a front-panel style CPU system.
module panel_controller #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        switches_status [0:24],
    output logic [0:35]       leds_status,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              cpu_run,
    output logic              cpu_step,
    output logic              cpu_reset,
    input  logic [15:0]       cpu_addr,
    input  logic [7:0]        cpu_data,
    input  logic [9:0]        cpu_status
);

    typedef enum logic [2:0] {
        S_OFF,
        S_IDLE,
        S_RUNNING,
        S_RD,
        S_WR
    } state_t;

    typedef enum logic [3:0] {
        C_NONE,
        C_RESET,
        C_STOP,
        C_RUN,
        C_STEP,
        C_EXAM,
        C_EXNEXT,
        C_DEP,
        C_DEPNEXT
    } cmd_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_data;
    logic [1:0]          r_prev [0:4];
    logic                r_armed;
    logic                r_mem_req;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic                r_cpu_run;
    logic                r_cpu_step;
    logic                r_cpu_reset;
    logic [0:35]         r_leds;

    logic                w_power;
    logic                w_run_en;
    logic [15:0]         w_sw_addr;
    logic [ADDR_W-1:0]   w_sw_addr_ext;
    logic [DATA_W-1:0]   w_sw_data;
    logic [ADDR_W-1:0]   w_addr_inc;
    logic [4:0]          w_up;
    logic [4:0]          w_dn;
    cmd_t                w_cmd;
    logic [0:35]         w_leds_next;
    logic                w_unused;

    assign w_power  = switches_status[16][0];
    assign w_run_en = switches_status[17][0];

    // Switch 0 is A15, switch 15 is A0
    always_comb begin
        w_sw_addr = '0;
        for (int i = 0; i < 16; i++) begin
            w_sw_addr[15-i] = switches_status[i][0];
        end
    end

    assign w_sw_addr_ext = ADDR_W'(w_sw_addr);
    assign w_sw_data     = DATA_W'(w_sw_addr[7:0]);
    assign w_addr_inc    = r_addr + ADDR_W'(1);

    // r_armed suppresses firing on the first cycle after reset release
    always_comb begin
        w_up = '0;
        w_dn = '0;
        for (int k = 0; k < 5; k++) begin
            w_up[k] = r_armed && (r_prev[k] == 2'd0)
                      && (switches_status[18+k] == 2'd2);
            w_dn[k] = r_armed && (r_prev[k] == 2'd0)
                      && (switches_status[18+k] == 2'd1);
        end
    end

    always_comb begin
        w_cmd = C_NONE;
        case (1'b1)
            w_up[4], w_dn[4]: w_cmd = C_RESET;
            w_up[0]:          w_cmd = C_STOP;
            w_dn[0]:          w_cmd = C_RUN;
            w_up[1]:          w_cmd = C_STEP;
            w_up[2]:          w_cmd = C_EXAM;
            w_dn[2]:          w_cmd = C_EXNEXT;
            w_up[3]:          w_cmd = C_DEP;
            w_dn[3]:          w_cmd = C_DEPNEXT;
            default:          w_cmd = C_NONE;
        endcase
    end

    always_comb begin
        w_leds_next = '0;
        if (w_power && r_state == S_RUNNING) begin
            w_leds_next = {cpu_addr, cpu_data, cpu_status, 2'b00};
        end else if (w_power && r_state != S_OFF) begin
            w_leds_next = {16'(r_addr), 8'(r_data), 10'd0, 2'b10};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_OFF;
            r_addr      <= '0;
            r_data      <= '0;
            r_armed     <= 1'b0;
            for (int k = 0; k < 5; k++) begin
                r_prev[k] <= 2'd0;
            end
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_cpu_run   <= 1'b0;
            r_cpu_step  <= 1'b0;
            r_cpu_reset <= 1'b0;
            r_leds      <= '0;
        end else begin
            r_armed     <= 1'b1;
            for (int k = 0; k < 5; k++) begin
                r_prev[k] <= switches_status[18+k];
            end
            r_cpu_step  <= 1'b0;
            r_cpu_reset <= 1'b0;
            r_leds      <= w_leds_next;
            if (!w_power) begin
                r_state   <= S_OFF;
                r_mem_req <= 1'b0;
                r_cpu_run <= 1'b0;
            end else begin
                case (r_state)
                    S_OFF: r_state <= S_IDLE;
                    S_IDLE: begin
                        case (w_cmd)
                            C_RESET: begin
                                r_cpu_reset <= 1'b1;
                                r_addr      <= '0;
                            end
                            C_RUN: begin
                                if (w_run_en) begin
                                    r_state   <= S_RUNNING;
                                    r_cpu_run <= 1'b1;
                                end
                            end
                            C_STEP: r_cpu_step <= 1'b1;
                            C_EXAM: begin
                                r_addr  <= w_sw_addr_ext;
                                r_state <= S_RD;
                            end
                            C_EXNEXT: begin
                                r_addr  <= w_addr_inc;
                                r_state <= S_RD;
                            end
                            C_DEP: begin
                                r_data  <= w_sw_data;
                                r_state <= S_WR;
                            end
                            C_DEPNEXT: begin
                                r_addr  <= w_addr_inc;
                                r_data  <= w_sw_data;
                                r_state <= S_WR;
                            end
                            default: ;
                        endcase
                    end
                    S_RUNNING: begin
                        if (w_cmd == C_RESET) begin
                            r_cpu_reset <= 1'b1;
                        end
                        if (w_cmd == C_STOP || !w_run_en) begin
                            r_state   <= S_IDLE;
                            r_cpu_run <= 1'b0;
                        end
                    end
                    S_RD, S_WR: begin
                        if (!r_mem_req) begin
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= (r_state == S_WR);
                            r_mem_addr  <= r_addr;
                            r_mem_wdata <= r_data;
                        end else if (mem_ack) begin
                            r_mem_req <= 1'b0;
                            r_state   <= S_IDLE;
                            if (r_state == S_RD) begin
                                r_data <= mem_rdata;
                            end
                        end
                    end
                    default: r_state <= S_OFF;
                endcase
            end
        end
    end

    assign leds_status = r_leds;
    assign mem_req     = r_mem_req;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign cpu_run     = r_cpu_run;
    assign cpu_step    = r_cpu_step;
    assign cpu_reset   = r_cpu_reset;

    // Upper bits of single-throw switches and the AUX switches carry no function
    always_comb begin
        w_unused = 1'b0;
        for (int i = 0; i < 18; i++) begin
            w_unused = w_unused ^ switches_status[i][1];
        end
        w_unused = w_unused ^ (^switches_status[23]) ^ (^switches_status[24]);
    end

endmodule

// File: tb/tb_panel_controller.sv
// Scoreboard bench for panel_controller: random panel operations
// against a task-level model of panel address/data and memory.
module tb_panel_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  sws [0:24];
    logic [0:35] leds;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
    logic        cpu_run;
    logic        cpu_step;
    logic        cpu_reset;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data;
    logic [9:0]  cpu_status;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  data;
    } txn_t;

    txn_t       exp_q [$];
    logic [7:0] env_mem [0:65535];
    logic [7:0] ref_mem [0:65535];
    int         checks = 0;
    int         failures = 0;
    int         ack_lat = 2;
    int         lat_cnt = 0;
    int         n_done = 0;
    int         n_step = 0;
    int         n_rst = 0;
    int         e_step = 0;
    int         e_rst = 0;
    logic [15:0] m_addr;
    logic [7:0]  m_data;

    always #5 clk = ~clk;

    panel_controller #(.ADDR_W(16), .DATA_W(8)) dut (
        .clk             (clk),
        .reset           (reset),
        .switches_status (sws),
        .leds_status     (leds),
        .mem_req         (mem_req),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .mem_ack         (mem_ack),
        .cpu_run         (cpu_run),
        .cpu_step        (cpu_step),
        .cpu_reset       (cpu_reset),
        .cpu_addr        (cpu_addr),
        .cpu_data        (cpu_data),
        .cpu_status      (cpu_status)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory responder: acks after ack_lat cycles of mem_req
    initial begin
        mem_ack = 1'b0;
        mem_rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (mem_ack) begin
                mem_ack = 1'b0;
            end else if (mem_req) begin
                if (lat_cnt >= ack_lat) begin
                    lat_cnt = 0;
                    mem_ack = 1'b1;
                    if (mem_we) env_mem[mem_addr] = mem_wdata;
                    else mem_rdata = env_mem[mem_addr];
                end else begin
                    lat_cnt++;
                end
            end else begin
                lat_cnt = 0;
            end
        end
    end

    // Monitor: pops the scoreboard on every completed handshake
    initial begin
        txn_t hold;
        txn_t e;
        logic holding;
        holding = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (mem_req && holding)
                chk("req_stable", {mem_we, mem_addr, mem_wdata}, hold);
            if (mem_req && !holding) begin
                hold = {mem_we, mem_addr, mem_wdata};
                holding = 1'b1;
            end
            if (!mem_req) holding = 1'b0;
            if (mem_req && mem_ack) begin
                n_done++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_txn: got we=%0b addr=%0h required none",
                             mem_we, mem_addr);
                end else begin
                    e = exp_q.pop_front();
                    chk("txn_we", 64'(mem_we), 64'(e.we));
                    chk("txn_addr", 64'(mem_addr), 64'(e.addr));
                    if (e.we) chk("txn_wdata", 64'(mem_wdata), 64'(e.data));
                end
            end
            if (cpu_step) n_step++;
            if (cpu_reset) n_rst++;
        end
    end

    function automatic logic [0:35] idle_leds(input logic [15:0] a,
                                              input logic [7:0] d);
        logic [0:35] l;
        l = '0;
        l[0:15] = a;
        l[16:23] = d;
        l[34] = 1'b1;
        return l;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_addr(input logic [15:0] a);
        for (int i = 0; i < 16; i++) sws[i] = {1'b0, a[15-i]};
    endtask

    task automatic flip(input int idx, input logic [1:0] v);
        @(negedge clk);
        sws[idx] = v;
        tick(2);
        sws[idx] = 2'd0;
        tick(1);
    endtask

    task automatic wait_txn();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            tick(1);
            #2;
            n++;
        end
        chk("txn_done", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic wait_req();
        int n;
        n = 0;
        while (!mem_req && n < 20) begin
            tick(1);
            #1;
            n++;
        end
        chk("req_seen", 64'(mem_req), 64'd1);
    endtask

    task automatic chk_idle(input string nm);
        tick(3);
        #1;
        chk(nm, 64'(leds), 64'(idle_leds(m_addr, m_data)));
    endtask

    task automatic op_exam(input logic [15:0] a);
        set_addr(a);
        m_addr = a;
        m_data = ref_mem[a];
        exp_q.push_back({1'b0, a, 8'h00});
        flip(20, 2'd2);
        wait_txn();
        chk_idle("exam_leds");
    endtask

    task automatic op_exnext();
        m_addr = m_addr + 16'd1;
        m_data = ref_mem[m_addr];
        exp_q.push_back({1'b0, m_addr, 8'h00});
        flip(20, 2'd1);
        wait_txn();
        chk_idle("exnext_leds");
    endtask

    task automatic op_dep(input logic [7:0] d, input logic nxt);
        set_addr({8'($urandom), d});
        if (nxt) m_addr = m_addr + 16'd1;
        m_data = d;
        ref_mem[m_addr] = d;
        exp_q.push_back({1'b1, m_addr, d});
        flip(21, nxt ? 2'd1 : 2'd2);
        wait_txn();
        chk_idle("dep_leds");
    endtask

    task automatic op_step();
        e_step++;
        flip(19, 2'd2);
        #1;
        chk("step_cnt", 64'(n_step), 64'(e_step));
        chk_idle("step_leds");
    endtask

    task automatic op_reset(input logic [1:0] v);
        e_rst++;
        m_addr = 16'h0000;
        flip(22, v);
        #1;
        chk("rst_cnt", 64'(n_rst), 64'(e_rst));
        chk_idle("reset_leds");
    endtask

    initial begin
        int n0;
        logic [0:35] run_l;
        logic [15:0] a;
        reset = 1'b0;
        for (int i = 0; i < 25; i++) sws[i] = 2'd0;
        cpu_addr = 16'h0;
        cpu_data = 8'h0;
        cpu_status = 10'h0;
        for (int i = 0; i < 65536; i++) begin
            env_mem[i] = 8'($urandom);
            ref_mem[i] = env_mem[i];
        end
        m_addr = 16'h0;
        m_data = 8'h0;

        tick(3);
        #1;
        chk("rst_leds", 64'(leds), 64'd0);
        chk("rst_mem", {mem_req, mem_we, mem_addr, mem_wdata}, 64'd0);
        chk("rst_cpu", {cpu_run, cpu_step, cpu_reset}, 64'd0);
        @(negedge clk);
        reset = 1'b1;

        tick(2);
        #1;
        chk("off_leds", 64'(leds), 64'd0);
        flip(20, 2'd2);
        tick(6);
        chk("off_ignore", 64'(n_done), 64'd0);
        @(negedge clk);
        sws[16] = 2'd1;
        chk_idle("power_on_leds");

        ack_lat = 3;
        env_mem[16'h1234] = 8'hAB;
        ref_mem[16'h1234] = 8'hAB;
        op_exam(16'h1234);
        chk("exam_count", 64'(n_done), 64'd1);

        ack_lat = 5;
        op_exam(16'hFFFF);
        op_dep(8'h5A, 1'b1);

        sws[17] = 2'd1;
        cpu_addr = 16'($urandom);
        cpu_data = 8'($urandom);
        cpu_status = 10'($urandom);
        flip(18, 2'd1);
        #1;
        chk("run_on", 64'(cpu_run), 64'd1);
        tick(2);
        #1;
        run_l = {cpu_addr, cpu_data, cpu_status, 2'b00};
        chk("run_leds", 64'(leds), 64'(run_l));
        cpu_addr = 16'($urandom);
        cpu_status = 10'($urandom);
        tick(2);
        #1;
        run_l = {cpu_addr, cpu_data, cpu_status, 2'b00};
        chk("run_leds_track", 64'(leds), 64'(run_l));
        n0 = n_done;
        flip(20, 2'd2);
        tick(8);
        chk("run_ignore_exam", 64'(n_done), 64'(n0));

        @(negedge clk);
        sws[18] = 2'd2;
        sws[22] = 2'd2;
        tick(2);
        sws[18] = 2'd0;
        sws[22] = 2'd0;
        tick(1);
        e_rst++;
        #1;
        chk("stop_rst_cnt", 64'(n_rst), 64'(e_rst));
        chk("stop_dropped", 64'(cpu_run), 64'd1);

        @(negedge clk);
        sws[17] = 2'd0;
        @(negedge clk);
        #1;
        chk("run_off", 64'(cpu_run), 64'd0);
        chk_idle("run_off_leds");
        flip(18, 2'd1);
        #1;
        chk("run_disabled", 64'(cpu_run), 64'd0);

        ack_lat = 8;
        a = 16'($urandom);
        set_addr(a);
        m_addr = a;
        m_data = ref_mem[a];
        exp_q.push_back({1'b0, a, 8'h00});
        n0 = n_done;
        @(negedge clk);
        sws[20] = 2'd2;
        tick(3);
        sws[20] = 2'd0;
        tick(1);
        sws[20] = 2'd2;
        tick(1);
        sws[20] = 2'd0;
        wait_txn();
        tick(3);
        chk("no_requeue", 64'(n_done - n0), 64'd1);
        chk_idle("requeue_leds");

        ack_lat = 40;
        a = 16'($urandom);
        set_addr(a);
        exp_q.push_back({1'b0, a, 8'h00});
        @(negedge clk);
        sws[20] = 2'd2;
        wait_req();
        sws[20] = 2'd0;
        @(negedge clk);
        sws[16] = 2'd0;
        @(negedge clk);
        #1;
        chk("pwr_drop_req", 64'(mem_req), 64'd0);
        chk("pwr_drop_leds", 64'(leds), 64'd0);
        exp_q.delete();
        m_addr = a;
        sws[16] = 2'd1;
        chk_idle("pwr_back_leds");

        set_addr(16'($urandom));
        exp_q.push_back({1'b1, m_addr, 8'h00});
        @(negedge clk);
        sws[21] = 2'd2;
        wait_req();
        @(negedge clk);
        sws[21] = 2'd0;
        sws[20] = 2'd2;
        reset = 1'b0;
        #1;
        chk("rst_abort_req", 64'(mem_req), 64'd0);
        tick(2);
        reset = 1'b1;
        exp_q.delete();
        m_addr = 16'h0;
        m_data = 8'h0;
        n0 = n_done;
        tick(6);
        #1;
        chk("held_no_fire", 64'(n_done), 64'(n0));
        chk("held_no_req", 64'(mem_req), 64'd0);
        chk_idle("rst_release_leds");
        sws[20] = 2'd0;
        tick(2);

        for (int it = 0; it < 40; it++) begin
            ack_lat = $urandom_range(0, 4);
            case ($urandom_range(0, 5))
                0: op_exam(16'($urandom));
                1: op_exnext();
                2: op_dep(8'($urandom), 1'b0);
                3: op_dep(8'($urandom), 1'b1);
                4: op_step();
                default: op_reset($urandom_range(0, 1) ? 2'd1 : 2'd2);
            endcase
        end

        tick(4);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
